// File: rtl/song_reader_if.sv
`default_nettype none
// ============================================================================
// Module : song_reader_if
// Brief  : Control, ROM and note-player signals of the song reader.
// Rev    : 1.0
// ============================================================================
interface song_reader_if #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6,
    parameter int IDX_W  = 5,
    parameter int SONG_W = 2
);
    logic                      play;
    logic [SONG_W-1:0]         song;
    logic                      note_done;
    logic [SONG_W+IDX_W-1:0]   rom_addr;
    logic [NOTE_W+DUR_W-1:0]   rom_data;
    logic [NOTE_W-1:0]         note;
    logic [DUR_W-1:0]          duration;
    logic                      new_note;
    logic                      song_done;

    // Environment side: control unit, song ROM and note player.
    modport master (
        output play, song, note_done, rom_data,
        input  rom_addr, note, duration, new_note, song_done
    );

    modport slave (
        input  play, song, note_done, rom_data,
        output rom_addr, note, duration, new_note, song_done
    );
endinterface
`default_nettype wire

// File: rtl/song_reader.sv
`default_nettype none
// ============================================================================
// Module : song_reader
// Brief  : Walks one song's note list in ROM and hands notes to the player.
// Rev    : 1.0
// ============================================================================
module song_reader #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6,
    parameter int IDX_W  = 5,
    parameter int SONG_W = 2
) (
    input  wire logic clk,
    input  wire logic reset,
    song_reader_if.slave bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_LATCH     = 3'd2;
    localparam logic [2:0] S_NEW_NOTE  = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_END       = 3'd5;

    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [IDX_W-1:0]  index;
    logic [NOTE_W-1:0] note_q;
    logic [DUR_W-1:0]  dur_q;

    logic [NOTE_W-1:0] rom_note;
    logic [DUR_W-1:0]  rom_dur;
    logic              last_note;

    assign rom_note  = bus.rom_data[NOTE_W+DUR_W-1 -: NOTE_W];
    assign rom_dur   = bus.rom_data[DUR_W-1:0];
    assign last_note = (index == LAST_IDX);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (bus.play) state_next = S_FETCH;
            S_FETCH:     if (bus.play) state_next = S_LATCH;
            // A zero duration is the end-of-song marker.
            S_LATCH:     state_next = (rom_dur == '0) ? S_END : S_NEW_NOTE;
            S_NEW_NOTE:  if (bus.play) state_next = S_WAIT_DONE;
            S_WAIT_DONE: if (bus.note_done) state_next = last_note ? S_END : S_FETCH;
            S_END:       state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            index  <= '0;
            note_q <= '0;
            dur_q  <= '0;
        end else begin
            state <= state_next;
            if (state == S_LATCH) begin
                note_q <= rom_note;
                dur_q  <= rom_dur;
            end
            // Index 31 never wraps: that note_done routes to END instead.
            if (state == S_WAIT_DONE && bus.note_done && !last_note)
                index <= index + 1'b1;
            if (state == S_END)
                index <= '0;
        end
    end

    assign bus.rom_addr  = {bus.song, index};
    assign bus.note      = note_q;
    assign bus.duration  = dur_q;
    assign bus.new_note  = (state == S_NEW_NOTE) && bus.play;
    assign bus.song_done = (state == S_END);

endmodule
`default_nettype wire
